// File: rtl/rca_8.sv
// 8-bit ripple-carry adder built from a chain of 1-bit full adders.
// Operands are captured when in_valid is high; the result is registered and
// appears one cycle later together with a single-cycle out_valid strobe.
module rca_8 (
  output logic       Cout,
  output logic [7:0] Sum,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       out_valid
);

  // One full-adder stage; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic p;
    p = a ^ b;
    return {(a & b) | (c & p), p ^ c};
  endfunction

  logic [8:0] carry_s;
  logic [7:0] sum_s;
  logic [7:0] sum_r;
  logic       cout_r;
  logic       valid_r;

  assign carry_s[0] = Cin;

  // Each stage consumes the carry rippled out of the stage below it.
  for (genvar i = 0; i < 8; i++) begin : g_stage
    assign {carry_s[i+1], sum_s[i]} = full_add(A[i], B[i], carry_s[i]);
  end

  // Result register: reset wins over capture; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= 8'h00;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (in_valid) begin
      sum_r   <= sum_s;
      cout_r  <= carry_s[8];
      valid_r <= 1'b1;
    end else begin
      sum_r   <= sum_r;
      cout_r  <= cout_r;
      valid_r <= 1'b0;
    end
  end

  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_rca_8.sv
// Self-checking bench for rca_8: directed vectors plus randomized traffic
// checked against an arithmetic reference model.
module tb_rca_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       in_valid;
  logic [7:0] Sum;
  logic       Cout;
  logic       out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the registered outputs should hold.
  logic [7:0] m_sum;
  logic       m_cout;
  logic       m_valid;

  rca_8 dut (
    .Cout      (Cout),
    .Sum       (Sum),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {v,co,sum}=%h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic v, input logic r, input string tag);
    logic [8:0] total;
    A = a; B = b; Cin = c; in_valid = v; rst = r;
    @(posedge clk);
    total = 9'(a) + 9'(b) + 9'(c);
    if (r) begin
      m_sum = 8'h00; m_cout = 1'b0; m_valid = 1'b0;
    end else if (v) begin
      m_sum = total[7:0]; m_cout = total[8]; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check(tag, {out_valid, Cout, Sum}, {m_valid, m_cout, m_sum});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t dir[10] = '{
    '{8'd161, 8'd16,  1'b0, 8'd177, 1'b0},
    '{8'd49,  8'd52,  1'b0, 8'd101, 1'b0},
    '{8'd0,   8'd1,   1'b0, 8'd1,   1'b0},
    '{8'd135, 8'd26,  1'b1, 8'd162, 1'b0},
    '{8'd62,  8'd7,   1'b1, 8'd70,  1'b0},
    '{8'd154, 8'd58,  1'b1, 8'd213, 1'b0},
    '{8'd97,  8'd65,  1'b1, 8'd163, 1'b0},
    '{8'd188, 8'd67,  1'b1, 8'd0,   1'b1},
    '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1},
    '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1}
  };

  initial begin
    A = 8'h00; B = 8'h00; Cin = 1'b0; in_valid = 1'b0; rst = 1'b1;
    m_sum = 8'h00; m_cout = 1'b0; m_valid = 1'b0;

    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "reset_idle");
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "reset_idle2");

    // Directed vectors, back to back, also checked against literal answers.
    foreach (dir[i]) begin
      step(dir[i].a, dir[i].b, dir[i].c, 1'b1, 1'b0, "directed");
      check("directed_const", {out_valid, Cout, Sum}, {1'b1, dir[i].co, dir[i].s});
    end

    // Hold: three idle cycles keep the last result, out_valid low.
    for (int k = 0; k < 3; k++) begin
      step($urandom_range(255, 0), $urandom_range(255, 0), 1'($urandom_range(1, 0)),
           1'b0, 1'b0, "hold");
      check("hold_const", {out_valid, Cout, Sum}, {1'b0, 1'b1, 8'd255});
    end

    // Reset beats a simultaneous valid operand set.
    step(8'd255, 8'd255, 1'b1, 1'b1, 1'b1, "rst_vs_valid");
    check("rst_vs_valid_const", {out_valid, Cout, Sum}, 10'h000);

    // Idle after reset: nothing pending may leak out.
    step(8'd10, 8'd20, 1'b0, 1'b0, 1'b0, "post_rst_idle");
    step(8'd10, 8'd20, 1'b1, 1'b1, 1'b0, "post_rst_first");

    // Random traffic with mixed valid density and occasional mid-stream reset.
    for (int k = 0; k < 400; k++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(3, 0) != 0), ($urandom_range(31, 0) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
